mem_ctrl_nch: RTL and testbench

- Parametrised successor to the two-operand memory controller: NCH operand channels of DW bits each, sharing one address bus to a single-port, NCH-lane-wide RAM.
- Loads a block of N words per channel from the host.
- Streams the stored words back, one address at a time, to the processing core under a done-handshake.
- Supports a clear mode and reports completion, errors and a running element count to core control.

---
 rtl/mem_ctrl_nch.sv | 193 +++++++++++++++++++
 tb/tb_mem_ctrl_nch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_nch.sv
// ============================================================================
// Module  : mem_ctrl_nch
// Purpose : NCH-lane memory controller. Loads N words per lane from the host
//           into a single-port RAM, streams them back one address at a time
//           to a core under a done-handshake, and can zero-fill a range.
// Ports   : mc_clk / mc_reset      - clock, synchronous active-high reset
//           mc_start/mc_mode/mc_length - command (00 LOAD, 01 STREAM,
//                                      10 LOAD then STREAM, 11 CLEAR)
//           mc_valid_data/mc_data_in  - host write data (lane k = [k*DW +: DW])
//           mc_data_out/_valid, procc_done - element presented to the core
//           mem_addr/mem_we/mem_wdata/mem_rdata - RAM port (1-cycle read)
//           mc_busy/mc_done/mc_err/mc_count - status to core control
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl_nch #(
  parameter int NCH = 2,
  parameter int DW  = 32,
  parameter int AW  = 6
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              mc_start,
  input  logic [1:0]        mc_mode,
  input  logic [AW:0]       mc_length,
  input  logic              mc_valid_data,
  input  logic [NCH*DW-1:0] mc_data_in,
  output logic [NCH*DW-1:0] mc_data_out,
  output logic              mc_data_out_valid,
  input  logic              procc_done,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [NCH*DW-1:0] mem_wdata,
  input  logic [NCH*DW-1:0] mem_rdata,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mc_err,
  output logic [AW:0]       mc_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_PRESENT  = 3'd4,
    S_CLEAR    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Largest legal block: the full RAM depth.
  localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};

  state_t              state_q, state_d;
  logic [1:0]          mode_q,  mode_d;
  logic [AW:0]         len_q,   len_d;
  logic [AW-1:0]       addr_q,  addr_d;
  logic [AW:0]         count_q, count_d;
  logic [NCH*DW-1:0]   dout_q,  dout_d;
  logic                dval_q,  dval_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                err_q,   err_d;

  logic [AW:0]         count_inc;
  logic                last_elem;

  assign count_inc = count_q + (AW+1)'(1);
  assign last_elem = (count_inc == len_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    addr_d  = addr_q;
    count_d = count_q;
    dout_d  = dout_q;
    dval_d  = dval_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mc_start) begin
          len_d = mc_length;
          if ((mc_length == '0) || (mc_length > MAX_N)) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mc_mode;
            addr_d  = '0;
            count_d = '0;
            case (mc_mode)
              2'b00, 2'b10: state_d = S_LOAD;
              2'b01:        state_d = S_RD_ISSUE;
              default:      state_d = S_CLEAR;
            endcase
          end
        end
      end

      S_LOAD: begin
        if (mc_valid_data) begin
          addr_d  = addr_q + AW'(1);
          count_d = count_inc;
          if (last_elem) begin
            if (mode_q == 2'b10) begin
              // Chained stream restarts both counters at element 0.
              addr_d  = '0;
              count_d = '0;
              state_d = S_RD_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_RD_ISSUE: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        dout_d  = mem_rdata;
        dval_d  = 1'b1;
        state_d = S_PRESENT;
      end

      S_PRESENT: begin
        if (procc_done) begin
          dval_d  = 1'b0;
          addr_d  = addr_q + AW'(1);
          count_d = count_inc;
          state_d = last_elem ? S_DONE : S_RD_ISSUE;
        end
      end

      S_CLEAR: begin
        addr_d  = addr_q + AW'(1);
        count_d = count_inc;
        if (last_elem) state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Status flags are registered images of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Host data passes straight to the RAM in the cycle it is valid; CLEAR
  // writes zeros every cycle it is active.
  assign mem_we    = ((state_q == S_LOAD) && mc_valid_data) || (state_q == S_CLEAR);
  assign mem_wdata = (state_q == S_LOAD) ? mc_data_in : '0;
  assign mem_addr  = addr_q;

  assign mc_data_out       = dout_q;
  assign mc_data_out_valid = dval_q;
  assign mc_busy           = busy_q;
  assign mc_done           = done_q;
  assign mc_err            = err_q;
  assign mc_count          = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl_nch.sv
// ============================================================================
// Module  : tb_mem_ctrl_nch
// Purpose : Scoreboard bench for mem_ctrl_nch. Expected RAM writes and
//           expected presented elements are queued as stimulus is issued;
//           negedge monitors pop and compare. Three DUT configurations.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl_nch;

  localparam int NCH = 2, DW = 32, AW = 6, W = NCH*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main DUT (NCH=2, DW=32, AW=6) ----------------
  logic          start, vdata, pdone, dval, mwe, busy, done, err;
  logic [1:0]    mode;
  logic [AW:0]   length, count;
  logic [W-1:0]  din, dout, mwdata, mrdata;
  logic [AW-1:0] maddr;

  mem_ctrl_nch #(.NCH(NCH), .DW(DW), .AW(AW)) u_dut (
    .mc_clk(clk), .mc_reset(rst), .mc_start(start), .mc_mode(mode),
    .mc_length(length), .mc_valid_data(vdata), .mc_data_in(din),
    .mc_data_out(dout), .mc_data_out_valid(dval), .procc_done(pdone),
    .mem_addr(maddr), .mem_we(mwe), .mem_wdata(mwdata), .mem_rdata(mrdata),
    .mc_busy(busy), .mc_done(done), .mc_err(err), .mc_count(count)
  );

  logic [W-1:0] ram [0:2**AW-1];
  always @(posedge clk) begin
    if (mwe) ram[maddr] <= mwdata;
    mrdata <= ram[maddr];
  end

  typedef struct packed { logic [AW-1:0] a; logic [W-1:0] d; } ent_t;
  ent_t         wq[$];
  ent_t         rq[$];
  logic [W-1:0] exp_mem [0:2**AW-1];
  ent_t         cur_w, cur_r;
  logic         dval_prev = 1'b0;
  int           done_cnt = 0;

  task automatic push_w(input logic [AW-1:0] a, input logic [W-1:0] d);
    wq.push_back({a, d});
    exp_mem[a] = d;
  endtask

  task automatic push_r(input logic [AW-1:0] a);
    rq.push_back({a, exp_mem[a]});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      dval_prev = 1'b0;
    end else begin
      if (mwe) begin
        if (wq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0h, required none", maddr, mwdata);
        end else begin
          cur_w = wq.pop_front();
          check("wr_addr", 64'(maddr), 64'(cur_w.a));
          check("wr_data", 64'(mwdata), 64'(cur_w.d));
        end
      end
      if (dval && !dval_prev) begin
        if (rq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_present: data %0h, required none", dout);
        end else begin
          cur_r = rq.pop_front();
        end
      end
      if (dval) begin
        check("rd_data", 64'(dout), 64'(cur_r.d));
        check("rd_addr_hold", 64'(maddr), 64'(cur_r.a));
      end
      dval_prev = dval;
      if (done) done_cnt++;
    end
  end

  // Core responder: raise procc_done on the gap-th PRESENT cycle of each
  // element (hold_len-th for element hold_elem); optional stray done
  // whenever nothing is presented.
  int   gap = 1, hold_elem = -1, hold_len = 1, eidx = 0, pcnt = 0;
  logic stray = 1'b0;
  initial pdone = 1'b0;
  always @(negedge clk) begin
    if (dval) begin
      pcnt++;
      pdone = (pcnt >= ((eidx == hold_elem) ? hold_len : gap));
      if (pdone) eidx++;
    end else begin
      pcnt  = 0;
      pdone = stray;
    end
  end

  task automatic cmd(input logic [1:0] m, input int n);
    start  = 1'b1;
    mode   = m;
    length = (AW+1)'(n);
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      if (done) got = 1'b1;
      else tick();
    end
    check(name, 64'(got), 64'(1));
  endtask

  // ---------------- sweep DUT 1 (NCH=1, DW=8, AW=3) ----------------
  logic       s1_start, s1_vd, s1_dval, s1_we, s1_busy, s1_done, s1_err;
  logic       s1_pdone = 1'b1;
  logic [1:0] s1_mode;
  logic [3:0] s1_len, s1_count;
  logic [7:0] s1_din, s1_dout, s1_wdata, s1_rdata;
  logic [2:0] s1_addr;

  mem_ctrl_nch #(.NCH(1), .DW(8), .AW(3)) u_s1 (
    .mc_clk(clk), .mc_reset(rst), .mc_start(s1_start), .mc_mode(s1_mode),
    .mc_length(s1_len), .mc_valid_data(s1_vd), .mc_data_in(s1_din),
    .mc_data_out(s1_dout), .mc_data_out_valid(s1_dval), .procc_done(s1_pdone),
    .mem_addr(s1_addr), .mem_we(s1_we), .mem_wdata(s1_wdata), .mem_rdata(s1_rdata),
    .mc_busy(s1_busy), .mc_done(s1_done), .mc_err(s1_err), .mc_count(s1_count)
  );

  logic [7:0] s1_ram [0:7];
  always @(posedge clk) begin
    if (s1_we) s1_ram[s1_addr] <= s1_wdata;
    s1_rdata <= s1_ram[s1_addr];
  end

  // ---------------- sweep DUT 2 (NCH=4, DW=16, AW=4) ----------------
  logic        s2_start, s2_vd, s2_dval, s2_we, s2_busy, s2_done, s2_err;
  logic        s2_pdone = 1'b1;
  logic [1:0]  s2_mode;
  logic [4:0]  s2_len, s2_count;
  logic [63:0] s2_din, s2_dout, s2_wdata, s2_rdata;
  logic [3:0]  s2_addr;

  mem_ctrl_nch #(.NCH(4), .DW(16), .AW(4)) u_s2 (
    .mc_clk(clk), .mc_reset(rst), .mc_start(s2_start), .mc_mode(s2_mode),
    .mc_length(s2_len), .mc_valid_data(s2_vd), .mc_data_in(s2_din),
    .mc_data_out(s2_dout), .mc_data_out_valid(s2_dval), .procc_done(s2_pdone),
    .mem_addr(s2_addr), .mem_we(s2_we), .mem_wdata(s2_wdata), .mem_rdata(s2_rdata),
    .mc_busy(s2_busy), .mc_done(s2_done), .mc_err(s2_err), .mc_count(s2_count)
  );

  logic [63:0] s2_ram [0:15];
  always @(posedge clk) begin
    if (s2_we) s2_ram[s2_addr] <= s2_wdata;
    s2_rdata <= s2_ram[s2_addr];
  end

  typedef struct packed { logic [2:0] a; logic [7:0]  d; } e1_t;
  typedef struct packed { logic [3:0] a; logic [63:0] d; } e2_t;
  e1_t s1_wq[$], s1_rq[$], e1;
  e2_t s2_wq[$], s2_rq[$], e2;

  always @(negedge clk) begin
    if (!rst) begin
      if (s1_we || s1_dval) begin
        if ((s1_we ? s1_wq.size() : s1_rq.size()) == 0) begin
          n_vec++; n_fail++;
          $display("FAIL s1_unexpected: we %0b valid %0b, required none", s1_we, s1_dval);
        end else if (s1_we) begin
          e1 = s1_wq.pop_front();
          check("s1_wr_addr", 64'(s1_addr), 64'(e1.a));
          check("s1_wr_data", 64'(s1_wdata), 64'(e1.d));
        end else begin
          e1 = s1_rq.pop_front();
          check("s1_rd_data", 64'(s1_dout), 64'(e1.d));
        end
      end
      if (s2_we || s2_dval) begin
        if ((s2_we ? s2_wq.size() : s2_rq.size()) == 0) begin
          n_vec++; n_fail++;
          $display("FAIL s2_unexpected: we %0b valid %0b, required none", s2_we, s2_dval);
        end else if (s2_we) begin
          e2 = s2_wq.pop_front();
          check("s2_wr_addr", 64'(s2_addr), 64'(e2.a));
          check("s2_wr_data", s2_wdata, e2.d);
        end else begin
          e2 = s2_rq.pop_front();
          check("s2_rd_data", s2_dout, e2.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] d;
    logic         got;
    int           base;

    rst = 1'b1; start = 1'b0; mode = '0; length = '0; vdata = 1'b0; din = '0;
    s1_start = 1'b0; s1_mode = '0; s1_len = '0; s1_vd = 1'b0; s1_din = '0;
    s2_start = 1'b0; s2_mode = '0; s2_len = '0; s2_vd = 1'b0; s2_din = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  64'(busy),   64'(0));
    check("rst_done",  64'(done),   64'(0));
    check("rst_err",   64'(err),    64'(0));
    check("rst_count", 64'(count),  64'(0));
    check("rst_dval",  64'(dval),   64'(0));
    check("rst_dout",  64'(dout),   64'(0));
    check("rst_we",    64'(mwe),    64'(0));
    check("rst_addr",  64'(maddr),  64'(0));

    // Reset in the middle of a LOAD
    cmd(2'b00, 14);
    for (int i = 0; i < 5; i++) begin
      d = {32'(66600000 + i), 32'(11111111 * (i + 1))};
      vdata = 1'b1; din = d; push_w(AW'(i), d);
      tick();
    end
    vdata = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; vdata = 1'b1; #1;
    check("midrst_busy",  64'(busy),  64'(0));
    check("midrst_we",    64'(mwe),   64'(0));
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_addr",  64'(maddr), 64'(0));
    vdata = 1'b0;
    tick();

    // LOAD then STREAM, N=14, valid gaps, done on 2nd PRESENT cycle
    gap = 2; hold_elem = -1; eidx = 0; base = done_cnt;
    cmd(2'b10, 14);
    for (int i = 0; i < 14; i++) begin
      if (i == 3 || i == 7 || i == 11) begin
        vdata = 1'b0; tick();
      end
      d = {32'(66600000 + i), 32'(11111111 * (i + 1))};
      vdata = 1'b1; din = d; push_w(AW'(i), d);
      tick();
    end
    vdata = 1'b0;
    for (int i = 0; i < 14; i++) push_r(AW'(i));
    wait_done("ls14_done", 300);
    check("ls14_count", 64'(count), 64'(14));
    tick();
    check("ls14_busy_after", 64'(busy), 64'(0));
    check("ls14_done_pulses", 64'(done_cnt - base), 64'(1));
    check("ls14_rq_empty", 64'(rq.size()), 64'(0));
    check("ls14_wq_empty", 64'(wq.size()), 64'(0));

    // Handshake hold with stray done outside PRESENT
    gap = 1; hold_elem = 1; hold_len = 21; eidx = 0; stray = 1'b1;
    for (int i = 0; i < 3; i++) push_r(AW'(i));
    cmd(2'b01, 3);
    wait_done("hold_done", 200);
    check("hold_count", 64'(count), 64'(3));
    check("hold_last_dout", 64'(dout), 64'(exp_mem[2]));
    stray = 1'b0; hold_elem = -1;
    tick();
    check("hold_dval_after", 64'(dval), 64'(0));
    check("hold_rq_empty", 64'(rq.size()), 64'(0));

    // Bounds: rejected lengths
    cmd(2'b00, 0);
    check("len0_err",  64'(err),  64'(1));
    check("len0_busy", 64'(busy), 64'(0));
    tick();
    check("len0_err_pulse", 64'(err), 64'(0));
    cmd(2'b11, 65);
    check("len65_err",  64'(err),  64'(1));
    check("len65_busy", 64'(busy), 64'(0));
    tick();
    check("len65_err_pulse", 64'(err), 64'(0));

    // Bounds: full depth LOAD, address wraps at the end
    cmd(2'b00, 64);
    for (int i = 0; i < 64; i++) begin
      d = {32'(32'hB000_0000 + i), 32'(32'hA000_0000 + i)};
      vdata = 1'b1; din = d; push_w(AW'(i), d);
      tick();
    end
    vdata = 1'b0;
    wait_done("len64_done", 20);
    check("len64_count", 64'(count), 64'(64));
    check("len64_addr_wrap", 64'(maddr), 64'(0));
    check("len64_wq_empty", 64'(wq.size()), 64'(0));
    tick();

    // CLEAR 0..7, then stream 0..8: address 8 keeps its loaded value
    for (int i = 0; i < 8; i++) push_w(AW'(i), '0);
    cmd(2'b11, 8);
    wait_done("clr_done", 40);
    check("clr_count", 64'(count), 64'(8));
    tick();
    gap = 1; eidx = 0;
    for (int i = 0; i < 9; i++) push_r(AW'(i));
    cmd(2'b01, 9);
    wait_done("clrrd_done", 100);
    check("clrrd_count", 64'(count), 64'(9));
    check("clrrd_addr8", 64'(dout), 64'({32'hB000_0008, 32'hA000_0008}));
    tick();
    check("clrrd_dval_after", 64'(dval), 64'(0));
    check("clrrd_rq_empty", 64'(rq.size()), 64'(0));

    // Sweep 1: NCH=1 DW=8 AW=3, full-depth load then stream
    s1_start = 1'b1; s1_mode = 2'b10; s1_len = 4'd8;
    tick();
    s1_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s1_vd = 1'b1; s1_din = 8'(8'hA0 + i);
      s1_wq.push_back({3'(i), 8'(8'hA0 + i)});
      s1_rq.push_back({3'(i), 8'(8'hA0 + i)});
      tick();
    end
    s1_vd = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (s1_done) got = 1'b1; else tick();
    end
    check("s1_done", 64'(got), 64'(1));
    check("s1_count", 64'(s1_count), 64'(8));
    check("s1_err", 64'(s1_err), 64'(0));
    tick();
    check("s1_busy_after", 64'(s1_busy), 64'(0));

    // Sweep 2: NCH=4 DW=16 AW=4, lane k carries 0x(k+1)000+i
    s2_start = 1'b1; s2_mode = 2'b10; s2_len = 5'd16;
    tick();
    s2_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) s2_din[k*16 +: 16] = 16'(16'h1000 * (k + 1) + i);
      s2_vd = 1'b1;
      s2_wq.push_back({4'(i), 16'(16'h4000 + i), 16'(16'h3000 + i), 16'(16'h2000 + i), 16'(16'h1000 + i)});
      s2_rq.push_back({4'(i), 16'(16'h4000 + i), 16'(16'h3000 + i), 16'(16'h2000 + i), 16'(16'h1000 + i)});
      tick();
    end
    s2_vd = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (s2_done) got = 1'b1; else tick();
    end
    check("s2_done", 64'(got), 64'(1));
    check("s2_count", 64'(s2_count), 64'(16));
    check("s2_err", 64'(s2_err), 64'(0));
    tick();
    check("s2_busy_after", 64'(s2_busy), 64'(0));
    check("sweep_queues_empty",
          64'(s1_wq.size() + s1_rq.size() + s2_wq.size() + s2_rq.size()), 64'(0));

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
